fpga2_receiver: RTL and testbench
=================================

// Module: fpga2_receiver
// PURPOSE
//  FPGA 2 side of the inter-FPGA link. Consumes data_out/req_out/send_done driven by the FPGA 1 sender.
//  Returns rdy/ack to the sender and buffers each burst in a FIFO.
//  Only bursts that pass the count check are committed and exposed to the local process.
//  A failed burst is rolled back and NACKed by dropping rdy, which makes the sender resend.
// PARAMETERS
//  DEPTH        512  FIFO depth in 32-bit words; power of two, >= 2
//  AW           9    log2(DEPTH); pointers are AW+1 bits wide
//  SYNC_STAGES  2    flops in the req/send_done synchronizers (>= 2)
//  NACK_CYCLES  4    cycles rdy_out is held low on a failed burst (>= 1)
// PORTS
//  clk           in   1    receiver clock
//  rst           in   1    synchronous, active-low reset
//  data_in       in   32   data word from the sender
//  req_in        in   1    request from the sender; asynchronous
//  send_done_in  in   1    end-of-burst from the sender; asynchronous, >= 3 sender cycles wide
//  recv_count    in   10   words expected per burst; sampled on IDLE->RECEIVE
//  rdy_out       out  1    ready to the sender; low while in NACK means failure
//  ack_out       out  1    burst accepted
//  out_data      out  32   head-of-FIFO word (first-word-fall-through)
//  out_valid     out  1    at least one committed word is available
//  out_ready     in   1    local process pops the head word when out_valid && out_ready
//  done          out  1    1-cycle pulse when a burst is committed
//  error         out  1    1-cycle pulse when a burst is rejected
//  fill          out  AW+1 committed word count (commit_ptr - rd_ptr)
// BEHAVIOUR
//  Reset (rst==0 at posedge): all outputs are 0, the FIFO is empty, all pointers are 0, state is IDLE.
//   Reset mid-burst discards everything, including committed words.
//  Sync: req_s and sd_s are the last synchronizer stages. sd_rise = sd_s & ~sd_s_d.
//   Inputs-to-response latency is SYNC_STAGES cycles. data_in is not synchronized.
//  Pointers: wr_ptr, commit_ptr and rd_ptr are AW+1 bits and wrap modulo 2*DEPTH.
//   full  = (wr_ptr - rd_ptr) == DEPTH.
//   empty = (commit_ptr == rd_ptr).
//   exp = 10-bit latched recv_count; wcnt = 10-bit burst word counter; ovf = overflow flag.
//  FSM:
//  IDLE: rdy_out=0, ack_out=0.
//   When req_s=1: exp<=recv_count, wcnt<=0, ovf<=0, go to RECEIVE.
//  RECEIVE: rdy_out=1.
//   Each cycle with wcnt<exp && !full: mem[wr_ptr]<=data_in, wr_ptr++, wcnt++.
//   If wcnt<exp && full: ovf<=1, nothing is written.
//   On sd_rise: go to CHECK; the capture in that same cycle still occurs.
//   If req_s==0 before sd_rise: wr_ptr<=commit_ptr, go to IDLE, no pulse.
//  CHECK (1 cycle): rdy_out=1.
//   Pass when wcnt==exp && !ovf: commit_ptr<=wr_ptr, done=1, go to ACK.
//   Otherwise: wr_ptr<=commit_ptr, error=1, go to NACK.
//  ACK: rdy_out=1, ack_out=1. Held until req_s==0, then go to IDLE.
//  NACK: rdy_out=0 for exactly NACK_CYCLES cycles, then go to IDLE.
//   Re-entry to RECEIVE happens once req_s is seen high in IDLE.
//  Read side:
//   out_valid=!empty; out_data=mem[rd_ptr[AW-1:0]]. Pop: rd_ptr++ in the same cycle.
//   Pops run in every state and concurrently with writes, commit and rollback.
//   Pop never passes commit_ptr.
//  exp==0 passes trivially on sd_rise: no words are written, done pulses, ack is sent.
//  Simultaneous commit and pop in one cycle: fill = old fill + burst words - 1.
//  Uncommitted words are never visible on out_data/out_valid.
// TESTING
//  T1 recv_count=4, req then words A0..A3 then send_done -> 4 words committed, done=1 once,
//     ack_out=1 until req drops; pops yield A0,A1,A2,A3 in order; fill returns to 0.
//  T2 recv_count=8, send_done after 5 words -> error=1, rdy_out=0 for 4 cycles, fill unchanged.
//     A resend of 8 words is then committed.
//  T3 DEPTH=16 test build, 10 words committed and not popped, burst of 8 -> ovf.
//     NACK follows, fill stays 10; after popping 10, the resend is accepted.
//  T4 req dropped mid-burst after 3 words -> IDLE, no done/error pulse, fill unchanged.
//  T5 recv_count=0, req then send_done -> done=1, ack_out=1, fill=0.
//  T6 out_ready held 1 while a 4-word burst commits (pointers wrapping past 2*DEPTH) -> every word
//     popped exactly once, in order; rst=0 mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fpga2_receiver.sv
// fpga2_receiver: inter-FPGA burst receiver with count check, commit/rollback FIFO and NACK-by-rdy.
module fpga2_receiver #(
    parameter int DEPTH       = 512,
    parameter int AW          = 9,
    parameter int SYNC_STAGES = 2,
    parameter int NACK_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   data_in,
    input  logic          req_in,
    input  logic          send_done_in,
    input  logic [9:0]    recv_count,
    output logic          rdy_out,
    output logic          ack_out,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          done,
    output logic          error,
    output logic [AW:0]   fill
);
    localparam int NW = $clog2(NACK_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, RECEIVE, CHECK, ACK, NACK} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] req_sync, sd_sync;
    logic sd_s_d, req_s, sd_s, sd_rise;
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
    logic [9:0] exp, wcnt;
    logic ovf, full, empty, pop, cap;
    logic [NW-1:0] ncnt;
    logic [31:0] mem [DEPTH];
    assign req_s     = req_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign sd_rise   = sd_s & ~sd_s_d;
    assign full      = (wr_ptr - rd_ptr) == DEPTH[AW:0];
    assign empty     = commit_ptr == rd_ptr;
    assign pop       = !empty && out_ready;
    assign cap       = state == RECEIVE && (sd_rise || req_s) && wcnt < exp;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fill      = commit_ptr - rd_ptr;
    always_ff @(posedge clk)
        if (cap && !full) mem[wr_ptr[AW-1:0]] <= data_in;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_sync   <= '0;
            sd_sync    <= '0;
            sd_s_d     <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            exp        <= '0;
            wcnt       <= '0;
            ovf        <= 1'b0;
            ncnt       <= '0;
            rdy_out    <= 1'b0;
            ack_out    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], send_done_in};
            sd_s_d   <= sd_s;
            done     <= 1'b0;
            error    <= 1'b0;
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            case (state)
                IDLE:
                    if (req_s) begin
                        exp     <= recv_count;
                        wcnt    <= '0;
                        ovf     <= 1'b0;
                        rdy_out <= 1'b1;
                        state   <= RECEIVE;
                    end
                RECEIVE: begin
                    if (cap && full) ovf <= 1'b1;
                    if (cap && !full) begin
                        wr_ptr <= wr_ptr + (AW+1)'(1);
                        wcnt   <= wcnt + 10'd1;
                    end
                    // send_done wins over a simultaneous req drop
                    if (sd_rise) state <= CHECK;
                    else if (!req_s) begin
                        wr_ptr  <= commit_ptr;
                        rdy_out <= 1'b0;
                        state   <= IDLE;
                    end
                end
                CHECK:
                    if (wcnt == exp && !ovf) begin
                        commit_ptr <= wr_ptr;
                        done       <= 1'b1;
                        ack_out    <= 1'b1;
                        state      <= ACK;
                    end else begin
                        wr_ptr  <= commit_ptr;
                        error   <= 1'b1;
                        rdy_out <= 1'b0;
                        ncnt    <= NW'(NACK_CYCLES - 1);
                        state   <= NACK;
                    end
                ACK:
                    if (!req_s) begin
                        rdy_out <= 1'b0;
                        ack_out <= 1'b0;
                        state   <= IDLE;
                    end
                NACK:
                    if (ncnt == '0) state <= IDLE;
                    else ncnt <= ncnt - NW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpga2_receiver.sv
// tb_fpga2_receiver: directed bursts with a commit-order scoreboard drained by a pop monitor.
module tb_fpga2_receiver;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int NACK_CYCLES = 4;
    logic clk = 1'b0, rst = 1'b0, req_in = 1'b0, send_done_in = 1'b0, out_ready = 1'b0;
    logic [31:0] data_in = '0;
    logic [9:0] recv_count = '0;
    logic rdy_out, ack_out, out_valid, done, error;
    logic [31:0] out_data;
    logic [AW:0] fill;
    int errors = 0, checks = 0, done_cnt = 0, err_cnt = 0;
    logic [31:0] q[$];

    fpga2_receiver #(.DEPTH(DEPTH), .AW(AW), .SYNC_STAGES(2), .NACK_CYCLES(NACK_CYCLES)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .req_in(req_in), .send_done_in(send_done_in),
        .recv_count(recv_count), .rdy_out(rdy_out), .ack_out(ack_out), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .done(done), .error(error), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pops are compared on the falling edge before the DUT advances rd_ptr.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) chk("pop_unexpected", out_valid, 0);
            else chk("pop_data", out_data, q.pop_front());
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (rdy_out !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("rdy_rise", rdy_out, 1);
    endtask

    task automatic pop_n(input int n);
        out_ready = 1'b1;
        tick(n);
        out_ready = 1'b0;
        chk("fill_after_pop", fill, q.size());
    endtask

    // n words are offered; the receiver captures during the send_done sync delay too.
    task automatic burst(input int expn, input int n, input logic [31:0] base);
        int d0, e0, avail;
        bit pass;
        avail = n < 3 ? 3 : n;
        pass = avail >= expn && expn <= DEPTH - q.size();
        recv_count = expn[9:0];
        req_in = 1'b1;
        wait_rdy();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < avail; i++) begin
            data_in = base + i;
            if (i == avail - 3) send_done_in = 1'b1;
            tick();
        end
        if (pass) for (int i = 0; i < expn; i++) q.push_back(base + i);
        send_done_in = 1'b0;
        tick();
        chk("done", done, pass);
        chk("error", error, !pass);
        chk("ack", ack_out, pass);
        chk("rdy_check", rdy_out, pass);
        chk("fill_commit", fill, q.size());
        if (pass) begin
            tick(2);
            chk("ack_hold", ack_out, 1);
        end else begin
            for (int i = 1; i < NACK_CYCLES; i++) begin
                tick();
                chk("nack_rdy", rdy_out, 0);
            end
        end
        req_in = 1'b0;
        tick(8);
        chk("ack_low", ack_out, 0);
        chk("rdy_low", rdy_out, 0);
        chk("done_once", done_cnt - d0, pass);
        chk("err_once", err_cnt - e0, !pass);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, e0;
        tick(3);
        chk("rst_rdy", rdy_out, 0);
        chk("rst_ack", ack_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_fill", fill, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b1;
        tick(2);
        // T1: basic 4-word burst
        burst(4, 4, 32'hA0);
        pop_n(4);
        // T2: short burst rejected, then resent
        burst(8, 5, 32'hB0);
        burst(8, 8, 32'hB0);
        pop_n(8);
        // T3: overflow with 10 committed words, resend after draining
        burst(10, 10, 32'hC0);
        burst(8, 8, 32'hD0);
        chk("ovf_fill", fill, 10);
        pop_n(10);
        burst(8, 8, 32'hD0);
        pop_n(8);
        // T4: req dropped mid-burst
        recv_count = 10'd6;
        req_in = 1'b1;
        wait_rdy();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'hE0 + i;
            tick();
        end
        req_in = 1'b0;
        tick(8);
        chk("abort_fill", fill, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_done", done_cnt - d0, 0);
        chk("abort_err", err_cnt - e0, 0);
        chk("abort_rdy", rdy_out, 0);
        // T5: zero-length burst
        burst(0, 0, 32'hF0);
        chk("zero_fill", fill, 0);
        // T6: continuous popping across pointer wrap
        out_ready = 1'b1;
        burst(4, 4, 32'h100);
        out_ready = 1'b0;
        chk("stream_fill", fill, 0);
        chk("stream_drained", q.size(), 0);
        // mid-burst reset discards committed and pending words
        burst(3, 3, 32'h200);
        recv_count = 10'd5;
        req_in = 1'b1;
        wait_rdy();
        for (int i = 0; i < 2; i++) begin
            data_in = 32'h300 + i;
            tick();
        end
        rst = 1'b0;
        tick();
        chk("mrst_rdy", rdy_out, 0);
        chk("mrst_ack", ack_out, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_fill", fill, 0);
        chk("mrst_done", done, 0);
        chk("mrst_error", error, 0);
        rst = 1'b1;
        req_in = 1'b0;
        q.delete();
        tick(4);
        burst(2, 2, 32'h400);
        pop_n(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
